// File: rtl/md5_crack_ctrl.sv
// Brute-force controller for a single md5 core: enumerates lowercase candidates
// in order of increasing length and stops at the first digest equal to the target.
module md5_crack_ctrl #(
    parameter int         MAX_LEN = 4,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7a
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [127:0]         target_digest,
    output logic [0:511]         md5_message,
    output logic [63:0]          md5_message_len,
    output logic                 md5_start,
    input  logic [127:0]         md5_digest,
    input  logic                 md5_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [8*MAX_LEN-1:0] result_message,
    output logic [3:0]           result_len,
    output logic [31:0]          attempts,
    output logic [2:0]           dbg_state
);

    // Core handshake: md5_start is a one-cycle pulse; the core drops md5_ready after
    // accepting it and raises it (level) when md5_digest is valid for that message.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_FOUND     = 3'd4,
        S_EXHAUSTED = 3'd5
    } state_t;

    state_t               state;
    logic [127:0]         target_q;
    logic [8*MAX_LEN-1:0] cand_q;
    logic [3:0]           len_q;

    logic [8*MAX_LEN-1:0] next_cand;
    logic [3:0]           next_len;
    logic                 carry;
    logic                 exhausted;

    // Candidate is kept right-justified with zeros above its length, so it maps
    // straight onto the low end of the message block.
    assign md5_message     = {{(512 - 8*MAX_LEN){1'b0}}, cand_q};
    assign md5_message_len = {57'd0, len_q, 3'd0};
    assign dbg_state       = state;

    // Odometer: rightmost character is least significant.
    always_comb begin
        next_cand = cand_q;
        next_len  = len_q;
        carry     = 1'b1;
        exhausted = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (4'(i) < len_q)) begin
                if (cand_q[8*i +: 8] == CHAR_HI) begin
                    next_cand[8*i +: 8] = CHAR_LO;
                end else begin
                    next_cand[8*i +: 8] = cand_q[8*i +: 8] + 8'd1;
                    carry               = 1'b0;
                end
            end
        end
        if (carry) begin
            if (len_q >= 4'(MAX_LEN)) begin
                exhausted = 1'b1;
            end else begin
                next_len = len_q + 4'd1;
                for (int i = 0; i < MAX_LEN; i++) begin
                    next_cand[8*i +: 8] = (4'(i) < next_len) ? CHAR_LO : 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            target_q       <= '0;
            cand_q         <= '0;
            len_q          <= '0;
            md5_start      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            found          <= 1'b0;
            result_message <= '0;
            result_len     <= '0;
            attempts       <= '0;
        end else begin
            case (state)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (go) begin
                        target_q  <= target_digest;
                        cand_q    <= {{(8*MAX_LEN - 8){1'b0}}, CHAR_LO};
                        len_q     <= 4'd1;
                        attempts  <= '0;
                        done      <= 1'b0;
                        found     <= 1'b0;
                        busy      <= 1'b1;
                        md5_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    md5_start <= 1'b0;
                    state     <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!md5_ready) state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (md5_ready) begin
                        if (attempts != 32'hFFFF_FFFF) attempts <= attempts + 32'd1;
                        if (md5_digest == target_q) begin
                            result_message <= cand_q;
                            result_len     <= len_q;
                            found          <= 1'b1;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                            state          <= S_FOUND;
                        end else if (exhausted) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_EXHAUSTED;
                        end else begin
                            cand_q    <= next_cand;
                            len_q     <= next_len;
                            md5_start <= 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    md5_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_crack_ctrl.sv
// Bench for md5_crack_ctrl: two instances (MAX_LEN 2 and 3) each driven by a
// behavioural core with random latency and a keyed stand-in hash.
module tb_md5_crack_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go_s [2];
    logic [127:0] tgt [2];
    logic [0:511] m_msg [2];
    logic [63:0]  m_len [2];
    logic         m_start [2];
    logic [127:0] m_dig [2];
    logic         m_rdy [2];
    logic         busy_s [2];
    logic         done_s [2];
    logic         found_s [2];
    logic [15:0]  res0;
    logic [23:0]  res1;
    logic [3:0]   rlen [2];
    logic [31:0]  att [2];
    logic [2:0]   dbg [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md5_crack_ctrl #(.MAX_LEN(2)) dut0 (
        .clk(clk), .reset(reset), .go(go_s[0]), .target_digest(tgt[0]),
        .md5_message(m_msg[0]), .md5_message_len(m_len[0]), .md5_start(m_start[0]),
        .md5_digest(m_dig[0]), .md5_ready(m_rdy[0]), .busy(busy_s[0]), .done(done_s[0]),
        .found(found_s[0]), .result_message(res0), .result_len(rlen[0]),
        .attempts(att[0]), .dbg_state(dbg[0]));

    md5_crack_ctrl #(.MAX_LEN(3)) dut1 (
        .clk(clk), .reset(reset), .go(go_s[1]), .target_digest(tgt[1]),
        .md5_message(m_msg[1]), .md5_message_len(m_len[1]), .md5_start(m_start[1]),
        .md5_digest(m_dig[1]), .md5_ready(m_rdy[1]), .busy(busy_s[1]), .done(done_s[1]),
        .found(found_s[1]), .result_message(res1), .result_len(rlen[1]),
        .attempts(att[1]), .dbg_state(dbg[1]));

    // ---------------- reference model ----------------
    typedef struct {
        logic [511:0] msg;
        int           n;
    } cand_t;

    // Candidate number idx (0 = "a") in length-then-lexicographic order, right-justified.
    function automatic cand_t ref_cand(input int idx);
        cand_t c;
        int    rem = idx;
        int    p = 26;
        c.msg = '0;
        c.n   = 1;
        while (rem >= p) begin
            rem = rem - p;
            c.n = c.n + 1;
            p   = p * 26;
        end
        for (int j = 0; j < c.n; j++) begin
            c.msg[8*j +: 8] = 8'h61 + 8'(rem % 26);
            rem = rem / 26;
        end
        return c;
    endfunction

    function automatic logic [127:0] fake_hash(input logic [511:0] m);
        return {32'h9e3779b9, m[63:0] ^ 64'h0123_4567_89ab_cdef, 32'h5a5a_a5a5};
    endfunction

    function automatic logic [127:0] dig(input int idx);
        cand_t c = ref_cand(idx);
        return fake_hash(c.msg);
    endfunction

    // ---------------- core model and handshake monitor ----------------
    typedef struct {
        int           k;
        logic [511:0] msg;
        logic [63:0]  len;
    } obs_t;
    obs_t obs_q[$];

    logic         core_busy [2];
    int           core_cnt [2];
    logic [511:0] core_msg [2];
    logic         prev_start [2];
    int width_err [2] = '{0, 0};
    int overlap_err [2] = '{0, 0};
    int stable_err [2] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_rdy[k]      <= 1'b1;
                m_dig[k]      <= '0;
                core_busy[k]  <= 1'b0;
                core_cnt[k]   <= 0;
                core_msg[k]   <= '0;
                prev_start[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                prev_start[k] <= m_start[k];
                if (m_start[k]) begin
                    if (prev_start[k]) width_err[k]++;
                    if (core_busy[k]) overlap_err[k]++;
                    obs_q.push_back('{k, m_msg[k], m_len[k]});
                    core_busy[k] <= 1'b1;
                    core_msg[k]  <= m_msg[k];
                    m_rdy[k]     <= 1'b0;
                    core_cnt[k]  <= $urandom_range(1, 4);
                end else if (core_busy[k]) begin
                    if (core_cnt[k] == 1) begin
                        if (m_msg[k] !== core_msg[k]) stable_err[k]++;
                        m_rdy[k]     <= 1'b1;
                        m_dig[k]     <= fake_hash(core_msg[k]);
                        core_busy[k] <= 1'b0;
                    end else begin
                        core_cnt[k] <= core_cnt[k] - 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_search(input int k, input logic [127:0] t);
        @(negedge clk);
        go_s[k] = 1'b1;
        tgt[k]  = t;
        @(negedge clk);
        go_s[k] = 1'b0;
        tgt[k]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int k, output bit ok);
        int n = 0;
        while (!done_s[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        ok = done_s[k];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy_s[k], done_s[k], found_s[k], m_start[k]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags[%0d] got %b want 0000", k, {busy_s[k], done_s[k], found_s[k], m_start[k]});
            end
            checks++;
            if (att[k] !== 32'd0 || rlen[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_counts[%0d] attempts %0d len %0d want 0 0", k, att[k], rlen[k]);
            end
            checks++;
            if (m_msg[k] !== 512'd0 || m_len[k] !== 64'd0) begin
                errors++;
                $display("FAIL reset_msg[%0d] len %0d want 0 and zero message", k, m_len[k]);
            end
        end
        checks++;
        if (res0 !== 16'd0 || res1 !== 24'd0) begin
            errors++;
            $display("FAIL reset_result got %h %h want 0 0", res0, res1);
        end
    endtask

    task automatic test_single_char;
        bit ok;
        start_search(0, dig(0));
        wait_done(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout done %b want 1", done_s[0]); end
        checks++;
        if (found_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_flags found %b busy %b want 1 0", found_s[0], busy_s[0]);
        end
        checks++;
        if (res0 !== 16'h0061 || rlen[0] !== 4'd1 || att[0] !== 32'd1) begin
            errors++;
            $display("FAIL single_result got %h len %0d att %0d want 0061 1 1", res0, rlen[0], att[0]);
        end
    endtask

    task automatic test_two_char;
        bit           ok;
        int           p = obs_q.size();
        logic [511:0] exp_q[$];
        logic [511:0] last_msg = '0;
        logic [63:0]  last_len = '0;
        start_search(0, dig(27));
        wait_done(0, ok);
        checks++;
        if (!ok || found_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL two_found done %b found %b want 1 1", done_s[0], found_s[0]);
        end
        checks++;
        if (res0 !== 16'h6162 || rlen[0] !== 4'd2 || att[0] !== 32'd28) begin
            errors++;
            $display("FAIL two_result got %h len %0d att %0d want 6162 2 28", res0, rlen[0], att[0]);
        end
        for (int i = 0; i < 28; i++) begin
            cand_t c = ref_cand(i);
            exp_q.push_back(c.msg);
        end
        for (int i = p; i < obs_q.size(); i++) begin
            if (obs_q[i].k == 0) begin
                logic [511:0] e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (obs_q[i].msg !== e) begin
                    errors++;
                    $display("FAIL two_seq[%0d] got %h want %h", i - p, obs_q[i].msg[31:0], e[31:0]);
                end
                last_msg = obs_q[i].msg;
                last_len = obs_q[i].len;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL two_seq_count missing %0d starts want 0", exp_q.size());
        end
        checks++;
        if (last_len !== 64'd16 || last_msg[15:0] !== 16'h6162) begin
            errors++;
            $display("FAIL two_last_start len %0d msg %h want 16 6162", last_len, last_msg[15:0]);
        end
    endtask

    task automatic test_exhaust;
        bit ok;
        start_search(0, dig(730));
        wait_done(0, ok);
        checks++;
        if (!ok || found_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_flags done %b found %b busy %b want 1 0 0", done_s[0], found_s[0], busy_s[0]);
        end
        checks++;
        if (att[0] !== 32'd702) begin
            errors++;
            $display("FAIL exhaust_attempts got %0d want 702", att[0]);
        end
    endtask

    task automatic test_len3;
        bit ok;
        start_search(1, dig(730));
        wait_done(1, ok);
        checks++;
        if (!ok || found_s[1] !== 1'b1) begin
            errors++;
            $display("FAIL len3_found done %b found %b want 1 1", done_s[1], found_s[1]);
        end
        checks++;
        if (res1 !== 24'h616263 || rlen[1] !== 4'd3 || att[1] !== 32'd731) begin
            errors++;
            $display("FAIL len3_result got %h len %0d att %0d want 616263 3 731", res1, rlen[1], att[1]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            bit    ok;
            int    k = $urandom_range(0, 1);
            int    idx = (k == 0) ? $urandom_range(0, 701) : $urandom_range(0, 900);
            cand_t c = ref_cand(idx);
            logic [23:0] got = (k == 0) ? {8'h00, res0} : res1;
            start_search(k, dig(idx));
            wait_done(k, ok);
            got = (k == 0) ? {8'h00, res0} : res1;
            checks++;
            if (!ok || found_s[k] !== 1'b1 || att[k] !== 32'(idx + 1)) begin
                errors++;
                $display("FAIL rand[%0d] dut%0d found %b att %0d want 1 %0d", it, k, found_s[k], att[k], idx + 1);
            end
            checks++;
            if (got !== c.msg[23:0] || rlen[k] !== 4'(c.n)) begin
                errors++;
                $display("FAIL rand_result[%0d] got %h len %0d want %h %0d", it, got, rlen[k], c.msg[23:0], c.n);
            end
        end
    endtask

    task automatic test_go_while_busy;
        int    idx = $urandom_range(100, 400);
        int    n = 0;
        cand_t c = ref_cand(idx);
        start_search(1, dig(idx));
        while (n < 20000) begin
            @(negedge clk);
            n++;
            if (done_s[1]) begin
                go_s[1] = 1'b0;
                break;
            end
            go_s[1] = ($urandom_range(0, 3) == 0);
            tgt[1]  = dig($urandom_range(0, 50));
        end
        go_s[1] = 1'b0;
        checks++;
        if (found_s[1] !== 1'b1 || att[1] !== 32'(idx + 1)) begin
            errors++;
            $display("FAIL busy_go found %b att %0d want 1 %0d", found_s[1], att[1], idx + 1);
        end
        checks++;
        if (res1 !== c.msg[23:0]) begin
            errors++;
            $display("FAIL busy_go_result got %h want %h", res1, c.msg[23:0]);
        end
    endtask

    task automatic test_handshake;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (width_err[k] != 0) begin errors++; $display("FAIL start_width[%0d] got %0d want 0", k, width_err[k]); end
            checks++;
            if (overlap_err[k] != 0) begin errors++; $display("FAIL start_while_wait[%0d] got %0d want 0", k, overlap_err[k]); end
            checks++;
            if (stable_err[k] != 0) begin errors++; $display("FAIL msg_stable[%0d] got %0d want 0", k, stable_err[k]); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n = 0;
        int p;
        start_search(1, dig(800));
        while (dbg[1] !== 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dbg[1] !== 3'd3) begin errors++; $display("FAIL mid_reach_wait state %0d want 3", dbg[1]); end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_s[1], done_s[1], found_s[1], m_start[1]} !== 4'b0000 || att[1] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_flags got %b att %0d want 0000 0", {busy_s[1], done_s[1], found_s[1], m_start[1]}, att[1]);
        end
        checks++;
        if (m_msg[1] !== 512'd0 || m_len[1] !== 64'd0 || res1 !== 24'd0 || rlen[1] !== 4'd0 || dbg[1] !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_regs len %0d res %h rlen %0d state %0d want 0", m_len[1], res1, rlen[1], dbg[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        p = obs_q.size();
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != p) begin errors++; $display("FAIL mid_no_start got %0d starts want 0", obs_q.size() - p); end
        start_search(1, dig(0));
        wait_done(1, ok);
        checks++;
        if (!ok || found_s[1] !== 1'b1 || att[1] !== 32'd1) begin
            errors++;
            $display("FAIL mid_restart found %b att %0d want 1 1", found_s[1], att[1]);
        end
    endtask

    task automatic test_back_to_back;
        bit    ok;
        int    p;
        cand_t c0 = ref_cand(0);
        start_search(0, dig(5));
        wait_done(0, ok);
        checks++;
        if (!ok || found_s[0] !== 1'b1 || att[0] !== 32'd6) begin
            errors++;
            $display("FAIL b2b_first found %b att %0d want 1 6", found_s[0], att[0]);
        end
        p = obs_q.size();
        start_search(0, dig(40));
        checks++;
        if (done_s[0] !== 1'b0 || found_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clear done %b found %b busy %b want 0 0 1", done_s[0], found_s[0], busy_s[0]);
        end
        wait_done(0, ok);
        checks++;
        if (obs_q.size() <= p || obs_q[p].msg !== c0.msg) begin
            errors++;
            $display("FAIL b2b_restart first candidate not 'a' (starts %0d)", obs_q.size() - p);
        end
        checks++;
        if (!ok || found_s[0] !== 1'b1 || att[0] !== 32'd41 || res0 !== 16'h616f) begin
            errors++;
            $display("FAIL b2b_second found %b att %0d res %h want 1 41 616f", found_s[0], att[0], res0);
        end
    endtask

    initial begin
        go_s[0] = 1'b0;
        go_s[1] = 1'b0;
        tgt[0]  = '0;
        tgt[1]  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_char();
        test_two_char();
        test_exhaust();
        test_len3();
        test_random();
        test_go_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
